// File: rtl/nabp_shifter_accumulator_pkg.sv
// nabp_shifter_accumulator_pkg: shared widths, states and constants for the LUT and the shifter sequencer
package nabp_shifter_accumulator_pkg;
  localparam int ANGLE_W = 9;
  localparam int ACCU_INT_W = 9;
  localparam int ACCU_FRAC_W = 12;
  localparam int NUM_LINES = 128;
  localparam int LINE_W = 7;
  localparam int ACCU_W = ACCU_INT_W + ACCU_FRAC_W;
  localparam logic [ACCU_W-1:0] ACCU_HALF = ACCU_W'(1) << (ACCU_FRAC_W - 1);
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, RUN} state_e;
endpackage

// File: rtl/nabp_shifter_line_counter.sv
// nabp_shifter_line_counter: per-projection line index with last-line flag
module nabp_shifter_line_counter
  import nabp_shifter_accumulator_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [LINE_W-1:0] line,
  output logic              last
);
  logic [LINE_W-1:0] line_q, line_d;
  always_comb line_d = clr ? '0 : inc ? line_q + 1'b1 : line_q;
  always_ff @(posedge clk) line_q <= reset ? '0 : line_d;
  assign line = line_q;
  assign last = line_q == LINE_W'(NUM_LINES - 1);
endmodule

// File: rtl/nabp_shifter_accumulator.sv
// nabp_shifter_accumulator: fetches a per-angle slope and streams one rounded shift per line
module nabp_shifter_accumulator
  import nabp_shifter_accumulator_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_valid,
  input  logic [ANGLE_W-1:0]           start_angle,
  output logic                         start_ready,
  output logic [ANGLE_W-1:0]           sh_angle,
  input  logic signed [ACCU_W-1:0]     sh_accu_base,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACCU_INT_W-1:0] out_shift,
  output logic [LINE_W-1:0]            out_line,
  output logic                         out_last
);
  state_e state_q, state_d;
  logic [ANGLE_W-1:0] sh_angle_q, sh_angle_d;
  logic [ACCU_W-1:0] base_q, base_d, accu_q, accu_d;
  logic out_valid_q, out_valid_d;
  logic fire, last, clr, inc;
  assign fire = out_valid_q && out_ready;
  always_comb begin
    state_d = state_q;
    sh_angle_d = sh_angle_q;
    base_d = base_q;
    accu_d = accu_q;
    out_valid_d = out_valid_q;
    clr = 1'b0;
    inc = 1'b0;
    case (state_q)
      IDLE: if (start_valid) begin
        sh_angle_d = start_angle;
        state_d = FETCH;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        base_d = sh_accu_base;
        accu_d = ACCU_HALF;
        clr = 1'b1;
        out_valid_d = 1'b1;
        state_d = RUN;
      end
      RUN: if (fire) begin
        if (last) begin
          out_valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          accu_d = accu_q + base_q;
          inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sh_angle_q <= '0;
      base_q <= '0;
      accu_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_angle_q <= sh_angle_d;
      base_q <= base_d;
      accu_q <= accu_d;
      out_valid_q <= out_valid_d;
    end
  end
  nabp_shifter_line_counter u_line (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (inc),
    .line  (out_line),
    .last  (last)
  );
  assign start_ready = state_q == IDLE;
  assign sh_angle = sh_angle_q;
  assign out_valid = out_valid_q;
  assign out_shift = accu_q[ACCU_W-1:ACCU_FRAC_W];
  assign out_last = last && out_valid_q;
endmodule
